// File: rtl/div_nbits_pkg.sv
// Shared definitions for the div_nbits restoring divider: state encoding,
// default width and counter sizing.
package div_nbits_pkg;

  localparam int DIV_N = 18;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    CALC = ST_CALC,
    DONE = ST_DONE
  } div_state_t;

  // The counter must hold 2N itself, hence 2N+1 distinct values.
  function automatic int cnt_width(input int n);
    return $clog2(2 * n + 1);
  endfunction

  localparam int DIV_CNT_W = cnt_width(DIV_N);

endpackage

// File: rtl/div_nbits_if.sv
// Operand/result handshake bundle for div_nbits. The master supplies operands
// and consumes results; the slave is the divider.
interface div_nbits_if
  import div_nbits_pkg::*;
#(
  parameter int N = DIV_N
);

  logic           In_valid;
  logic           In_ready;
  logic [2*N-1:0] Dividend;
  logic [N-1:0]   Divisor;
  logic           Out_valid;
  logic           Out_ready;
  logic [2*N-1:0] Quotient;
  logic [N-1:0]   Remainder;
  logic           Div0;

  modport master (
    output In_valid, Dividend, Divisor, Out_ready,
    input  In_ready, Out_valid, Quotient, Remainder, Div0
  );

  modport slave (
    input  In_valid, Dividend, Divisor, Out_ready,
    output In_ready, Out_valid, Quotient, Remainder, Div0
  );

endinterface

// File: rtl/div_nbits_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder and subtract the divisor if it fits.
module div_step
  import div_nbits_pkg::*;
#(
  parameter int N = DIV_N
) (
  input  logic [N-1:0] r_in,
  input  logic         bit_in,
  input  logic [N-1:0] d,
  output logic [N-1:0] r_out,
  output logic         q_bit
);

  // The shifted value needs N+1 bits; the result is always below d, so N suffice.
  logic [N:0] r_shift;
  logic [N:0] r_sub;

  always_comb begin
    r_shift = {r_in, bit_in};
    r_sub   = r_shift - {1'b0, d};
    q_bit   = (r_shift >= {1'b0, d});
    r_out   = q_bit ? r_sub[N-1:0] : r_shift[N-1:0];
  end

endmodule

// File: rtl/div_nbits.sv
// Sequential restoring divider: 2N-bit dividend / N-bit divisor, one quotient
// bit per clock. Define DIV_EARLY_EXIT_EN to skip the dividend's leading zeros.
module div_nbits
  import div_nbits_pkg::*;
#(
  parameter int N = DIV_N
) (
  input  logic        clk,
  input  logic        Rst_n,
  div_nbits_if.slave  bus
);

  localparam int QW = 2 * N;
  localparam int CW = cnt_width(N);

  div_state_t      state_reg, state_next;
  logic [QW-1:0]   q_reg, q_next;
  logic [N-1:0]    r_reg, r_next;
  logic [N-1:0]    d_reg, d_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic            div0_reg, div0_next;
  logic            live_reg;

  logic            in_ready;
  logic            done;
  logic [N-1:0]    step_r;
  logic            step_q;
  logic [QW-1:0]   load_q;
  logic [CW-1:0]   load_cnt;

  div_step #(.N(N)) u_step (
    .r_in   (r_reg),
    .bit_in (q_reg[QW-1]),
    .d      (d_reg),
    .r_out  (step_r),
    .q_bit  (step_q)
  );

`ifdef DIV_EARLY_EXIT_EN
  logic [CW-1:0] lz;

  // Leading zeros shift only zeros into R and Q, so skipping them is exact.
  always_comb begin
    lz = CW'(QW);
    for (int i = 0; i < QW; i++) begin
      if (bus.Dividend[i]) lz = CW'(QW - 1 - i);
    end
    load_q   = bus.Dividend << lz;
    load_cnt = (lz == CW'(QW)) ? CW'(1) : CW'(QW) - lz;
  end
`else
  always_comb begin
    load_q   = bus.Dividend;
    load_cnt = CW'(QW);
  end
`endif

  assign in_ready = live_reg && (state_reg == IDLE);
  assign done     = (state_reg == DONE);

  always_comb begin
    state_next = state_reg;
    q_next     = q_reg;
    r_next     = r_reg;
    d_next     = d_reg;
    cnt_next   = cnt_reg;
    div0_next  = div0_reg;
    case (state_reg)
      IDLE: begin
        if (bus.In_valid && in_ready) begin
          d_next    = bus.Divisor;
          r_next    = '0;
          div0_next = 1'b0;
          if (bus.Divisor == '0) begin
            q_next     = '1;
            r_next     = bus.Dividend[N-1:0];
            div0_next  = 1'b1;
            cnt_next   = '0;
            state_next = DONE;
          end else begin
            q_next     = load_q;
            cnt_next   = load_cnt;
            state_next = CALC;
          end
        end
      end
      CALC: begin
        q_next   = {q_reg[QW-2:0], step_q};
        r_next   = step_r;
        cnt_next = cnt_reg - CW'(1);
        if (cnt_reg == CW'(1)) state_next = DONE;
      end
      DONE: begin
        if (bus.Out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.In_ready  = in_ready;
    bus.Out_valid = done;
    bus.Quotient  = done ? q_reg : '0;
    bus.Remainder = done ? r_reg : '0;
    bus.Div0      = done ? div0_reg : 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!Rst_n) begin
      state_reg <= IDLE;
      q_reg     <= '0;
      r_reg     <= '0;
      d_reg     <= '0;
      cnt_reg   <= '0;
      div0_reg  <= 1'b0;
      live_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      q_reg     <= q_next;
      r_reg     <= r_next;
      d_reg     <= d_next;
      cnt_reg   <= cnt_next;
      div0_reg  <= div0_next;
      live_reg  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_div_nbits.sv
// Directed and random checks of div_nbits with N=18, in either build of
// DIV_EARLY_EXIT_EN.
module tb_div_nbits;

  localparam int N = 18;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  div_nbits_if #(.N(N)) bus ();

  div_nbits #(.N(N)) dut (
    .clk   (clk),
    .Rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected latency in edges, counting the accepting edge.
  function automatic int pick_lat(input int normal, input int early);
`ifdef DIV_EARLY_EXIT_EN
    return early;
`else
    return normal;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [63:0] dvd, input logic [63:0] dvs);
    int n;
    bus.In_valid = 1'b1;
    bus.Dividend = dvd[2*N-1:0];
    bus.Divisor  = dvs[N-1:0];
    n = 0;
    while (!bus.In_ready && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) check_val("accept_timeout", 64'd0, 64'd1);
    tick();
    bus.In_valid = 1'b0;
  endtask

  task automatic wait_result(input string tag, input int exp_lat);
    int lat;
    lat = 1;
    while (!bus.Out_valid && lat < 100) begin
      tick();
      lat++;
    end
    check_val({tag, "_valid"}, 64'(bus.Out_valid), 64'd1);
    if (exp_lat > 0) check_val({tag, "_latency"}, 64'(lat), 64'(exp_lat));
  endtask

  task automatic check_result(input string tag, input logic [63:0] q, input logic [63:0] r, input logic d0);
    $display("xact %s q=%0h r=%0h div0=%0b", tag, bus.Quotient, bus.Remainder, bus.Div0);
    check_val({tag, "_q"}, 64'(bus.Quotient), q);
    check_val({tag, "_r"}, 64'(bus.Remainder), r);
    check_val({tag, "_div0"}, 64'(bus.Div0), 64'(d0));
  endtask

  task automatic release_result(input string tag);
    bus.Out_ready = 1'b1;
    tick();
    bus.Out_ready = 1'b0;
    check_val({tag, "_drop"}, 64'(bus.Out_valid), 64'd0);
    check_val({tag, "_ready"}, 64'(bus.In_ready), 64'd1);
  endtask

  task automatic run_div(input string tag, input logic [63:0] dvd, input logic [63:0] dvs,
                         input logic [63:0] q, input logic [63:0] r, input logic d0, input int exp_lat);
    send(dvd, dvs);
    wait_result(tag, exp_lat);
    check_result(tag, q, r, d0);
    release_result(tag);
  endtask

  initial begin
    logic [63:0] dvd, dvs, eq, er;
    int sel;

    bus.In_valid  = 1'b0;
    bus.Dividend  = '0;
    bus.Divisor   = '0;
    bus.Out_ready = 1'b0;

    // Reset state
    repeat (3) tick();
    check_val("rst_in_ready", 64'(bus.In_ready), 64'd0);
    check_val("rst_out_valid", 64'(bus.Out_valid), 64'd0);
    check_val("rst_q", 64'(bus.Quotient), 64'd0);
    check_val("rst_r", 64'(bus.Remainder), 64'd0);
    check_val("rst_div0", 64'(bus.Div0), 64'd0);
    rst_n = 1'b1;
    tick();
    check_val("rel_in_ready", 64'(bus.In_ready), 64'd1);

    // Main function and boundaries
    run_div("d100_7", 64'd100, 64'd7, 64'd14, 64'd2, 1'b0, pick_lat(37, 8));
    run_div("max_max", 64'hF_FFFF_FFFF, 64'h3FFFF, 64'h4_0001, 64'd0, 1'b0, pick_lat(37, 37));
    run_div("max_one", 64'hF_FFFF_FFFF, 64'd1, 64'hF_FFFF_FFFF, 64'd0, 1'b0, pick_lat(37, 37));
    run_div("div0", 64'h12345, 64'd0, 64'hF_FFFF_FFFF, 64'h12345, 1'b1, 1);
    run_div("zero_dvd", 64'd0, 64'd7, 64'd0, 64'd0, 1'b0, pick_lat(37, 2));

    // Back-pressure in DONE, then back-to-back accept
    send(64'd1000, 64'd33);
    wait_result("stall", pick_lat(37, 11));
    for (int i = 0; i < 10; i++) begin
      bus.In_valid = i[0];
      bus.Dividend = 36'd5;
      bus.Divisor  = 18'd1;
      tick();
      check_val("stall_valid", 64'(bus.Out_valid), 64'd1);
      check_val("stall_in_ready", 64'(bus.In_ready), 64'd0);
      check_val("stall_q", 64'(bus.Quotient), 64'd30);
      check_val("stall_r", 64'(bus.Remainder), 64'd10);
    end
    check_result("stall", 64'd30, 64'd10, 1'b0);
    bus.In_valid  = 1'b1;
    bus.Dividend  = 36'd81;
    bus.Divisor   = 18'd9;
    bus.Out_ready = 1'b1;
    tick();
    bus.Out_ready = 1'b0;
    check_val("b2b_drop", 64'(bus.Out_valid), 64'd0);
    check_val("b2b_ready", 64'(bus.In_ready), 64'd1);
    run_div("b2b", 64'd81, 64'd9, 64'd9, 64'd0, 1'b0, pick_lat(37, 8));

    // Reset during CALC
    send(64'hABCDE12, 64'd3);
    repeat (9) tick();
    rst_n = 1'b0;
    tick();
    check_val("midrst_valid", 64'(bus.Out_valid), 64'd0);
    check_val("midrst_q", 64'(bus.Quotient), 64'd0);
    check_val("midrst_r", 64'(bus.Remainder), 64'd0);
    check_val("midrst_div0", 64'(bus.Div0), 64'd0);
    check_val("midrst_in_ready", 64'(bus.In_ready), 64'd0);
    tick();
    check_val("midrst_hold_ready", 64'(bus.In_ready), 64'd0);
    rst_n = 1'b1;
    tick();
    check_val("midrst_rel_ready", 64'(bus.In_ready), 64'd1);
    run_div("d50_5", 64'd50, 64'd5, 64'd10, 64'd0, 1'b0, pick_lat(37, 7));

    // Random operands against a behavioural reference
    for (int i = 0; i < 1000; i++) begin
      sel = $urandom_range(0, 9);
      dvd = {$urandom, $urandom};
      dvd = dvd & 64'hF_FFFF_FFFF;
      if (sel == 9) dvd = dvd & 64'hFFFF;
      dvs = 64'($urandom);
      if (sel == 0) dvs = 64'd0;
      else if (sel < 4) dvs = 64'($urandom_range(1, 255));
      else dvs = dvs & 64'h3FFFF;
      if (dvs == 64'd0) begin
        eq = 64'hF_FFFF_FFFF;
        er = dvd & 64'h3FFFF;
      end else begin
        eq = dvd / dvs;
        er = dvd % dvs;
      end
      run_div("rand", dvd, dvs, eq, er, (dvs == 64'd0), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/div_nbits.md
Name: div_Nbits

Overview:
- Sequential restoring divider; the inverse datapath to the MAC.
- Takes a 2N-bit accumulated value (MAC output width) and divides it by an N-bit divisor.
- Produces a 2N-bit quotient and an N-bit remainder, one quotient bit per clock.
- Used for averaging and normalising accumulator results; valid/ready handshake on both sides.

Parameters:
- N, 18, divisor/remainder width; dividend and quotient are 2N bits.

Ports:
- clk  input  1  clock, all state updates on posedge.
- Rst_n  input  1  reset, synchronous, active-low.
- In_valid  input  1  operands present.
- In_ready  output  1  block can accept operands.
- Dividend  input  2N  unsigned dividend.
- Divisor  input  N  unsigned divisor.
- Out_valid  output  1  result held on outputs.
- Out_ready  input  1  consumer takes result.
- Quotient  output  2N  unsigned quotient.
- Remainder  output  N  unsigned remainder.
- Div0  output  1  divisor was zero for the current result.

Behaviour:
- Interface: one clock, clk. Reset Rst_n is synchronous and active-low, sampled on posedge clk.
- Reset values: In_ready=0 during reset, then 1 from the first cycle after release. Out_valid=0, Quotient=0, Remainder=0, Div0=0. State=IDLE, counter=0.
- Reset mid-operation: abort with no output. Next cycle is IDLE and all outputs take their reset values.
- States: IDLE, CALC, DONE.
- IDLE: In_ready=1. On In_valid&&In_ready, latch Dividend into the quotient shift register Q and Divisor into D. Clear partial remainder R (N+1 bits) and load counter=2N.
  - Divisor==0 goes directly to DONE with Quotient=all ones, Remainder=Dividend[N-1:0], Div0=1.
  - Otherwise go to CALC.
- CALC: one iteration per cycle.
  - R' = {R[N-1:0], Q[2N-1]}; Q shifts left.
  - If R' >= {1'b0,D}: R = R'-D and Q[0]=1. Else R = R' and Q[0]=0.
  - counter decrements; after the iteration that reaches 0, go to DONE.
  - In_ready=0 in CALC and DONE; In_valid is ignored there.
- DONE: Out_valid=1. Quotient=Q, Remainder=R[N-1:0], Div0 as latched.
  - Outputs stay stable until Out_valid&&Out_ready, then return to IDLE.
  - Out_valid drops in the next cycle, and In_ready=1 in that same next cycle. There is no same-cycle accept/return bypass.
- Latency, nonzero divisor: Out_valid rises 2N+1 clocks after the accepting edge (2N CALC edges plus the DONE entry edge).
  - Divide-by-zero: Out_valid rises 1 clock after the accepting edge.
- Throughput: one division per 2N+2 cycles when Out_ready is held high.
- Arithmetic: unsigned only. Remainder < Divisor is always guaranteed for a nonzero divisor. Quotient never overflows 2N bits.
- Out_ready with Out_valid=0 has no effect.

Optional Feature:
- Macro DIV_EARLY_EXIT_EN.
- Defined: on accept, count leading zeros L of Dividend (0..2N), pre-shift Q left by L and load counter = max(2N-L, 1).
  - Latency becomes max(2N-L,1)+1 clocks. Dividend=0 gives 2 clocks, Q=0, R=0.
  - Results are bit-identical to the non-macro build.
- Undefined: fixed 2N iterations and no leading-zero logic.

Decomposition:
- Shared package/include holds:
  - state encoding localparams ST_IDLE=2'd0, ST_CALC=2'd1, ST_DONE=2'd2;
  - default width constant DIV_N=18;
  - counter width as clog2(2N+1).
- One natural sub-module, div_step: combinational single restoring iteration. Inputs R, next dividend bit, D; outputs new R and quotient bit.

Test Plan:
- N=18, Dividend=100, Divisor=7, Out_ready=1 -> Quotient=14, Remainder=2, Div0=0; Out_valid rises exactly 37 clocks after accept.
- Dividend=2^36-1, Divisor=2^18-1 -> Quotient=2^18+1, Remainder=0; also Divisor=1 -> Quotient=Dividend, Remainder=0.
- Divisor=0, Dividend=0x12345 -> Quotient=0xFFFFFFFFF, Remainder=0x12345, Div0=1; Out_valid one clock after accept.
- Out_ready held 0 for 10 cycles in DONE -> outputs stable, In_ready=0, In_valid pulses ignored. On Out_ready=1, In_ready=1 the next cycle and a back-to-back operand is accepted.
- Rst_n=0 asserted mid-CALC (iteration 10) -> next cycle Out_valid=0, outputs 0, In_ready=0 while reset is held, 1 after release; a fresh division of 50/5 then gives Q=10, R=0.
- DIV_EARLY_EXIT_EN defined: Dividend=100, Divisor=7 -> same Q/R, latency 8 clocks; Dividend=0 -> Q=0, R=0, latency 2. 1000 random operand pairs match a reference model in both builds.
